scan_sequencer: RTL and testbench

Channel scan sequencer that sits directly upstream of the 3-to-8 decoder and drives its 3-bit select input. On command it steps through the enabled channels of an 8-bit mask in ascending order and holds each for a programmable dwell time. It runs either one sweep or continuously, and reports progress with step/done pulses. An optional registered one-hot copy of the selection can be compiled in.

---
 rtl/scan_sequencer_if.sv | 53 +++++
 rtl/scan_sequencer.sv | 121 ++++++++++++
 tb/tb_scan_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/scan_sequencer_if.sv
// Handshake/bus bundle for scan_sequencer: command inputs and registered scan outputs.
// SCAN_SEQUENCER_ONEHOT_EN adds the registered one-hot select sel_oh_o.
interface scan_sequencer_if #(
    parameter int unsigned DWELL_W = 8
);
    logic               start_i;
    logic               stop_i;
    logic               cont_i;
    logic [7:0]         mask_i;
    logic [DWELL_W-1:0] dwell_i;
    logic [2:0]         sel_o;
    logic               sel_valid_o;
    logic               busy_o;
    logic               step_o;
    logic               done_o;
`ifdef SCAN_SEQUENCER_ONEHOT_EN
    logic [7:0]         sel_oh_o;
`endif

    modport master (
        output start_i,
        output stop_i,
        output cont_i,
        output mask_i,
        output dwell_i,
        input  sel_o,
        input  sel_valid_o,
        input  busy_o,
        input  step_o,
        input  done_o
`ifdef SCAN_SEQUENCER_ONEHOT_EN
        ,
        input  sel_oh_o
`endif
    );

    modport slave (
        input  start_i,
        input  stop_i,
        input  cont_i,
        input  mask_i,
        input  dwell_i,
        output sel_o,
        output sel_valid_o,
        output busy_o,
        output step_o,
        output done_o
`ifdef SCAN_SEQUENCER_ONEHOT_EN
        ,
        output sel_oh_o
`endif
    );
endinterface

// File: rtl/scan_sequencer.sv
// Channel scan sequencer: walks enabled mask channels in ascending order, dwell+1 cycles each.
// Define SCAN_SEQUENCER_ONEHOT_EN to add the registered one-hot output sel_oh_o.
module scan_sequencer #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    scan_sequencer_if.slave   bus
);
    typedef enum logic {IDLE, DWELL} state_t;

    state_t             state_q;
    logic [2:0]         sel_q;
    logic               sel_valid_q;
    logic               busy_q;
    logic               step_q;
    logic               done_q;
    logic               cont_q;
    logic [DWELL_W-1:0] cnt_q;
`ifdef SCAN_SEQUENCER_ONEHOT_EN
    logic [7:0]         sel_oh_q;
`endif

    logic [2:0] first_ch;
    logic       first_hit;
    logic [2:0] next_ch;
    logic       next_hit;

    // Lowest enabled channel overall, and lowest enabled channel strictly above sel_q.
    always_comb begin
        first_ch  = '0;
        first_hit = 1'b0;
        next_ch   = '0;
        next_hit  = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bus.mask_i[i] && !first_hit) begin
                first_ch  = 3'(i);
                first_hit = 1'b1;
            end
            if (bus.mask_i[i] && !next_hit && (i > 32'(sel_q))) begin
                next_ch  = 3'(i);
                next_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            step_q      <= 1'b0;
            done_q      <= 1'b0;
            cont_q      <= 1'b0;
            cnt_q       <= '0;
`ifdef SCAN_SEQUENCER_ONEHOT_EN
            sel_oh_q    <= '0;
`endif
        end else begin
            step_q <= 1'b0;
            done_q <= 1'b0;
            if (bus.stop_i) begin
                state_q     <= IDLE;
                sel_valid_q <= 1'b0;
                busy_q      <= 1'b0;
`ifdef SCAN_SEQUENCER_ONEHOT_EN
                sel_oh_q    <= '0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start_i && first_hit) begin
                            state_q     <= DWELL;
                            sel_q       <= first_ch;
                            cnt_q       <= bus.dwell_i;
                            cont_q      <= bus.cont_i;
                            sel_valid_q <= 1'b1;
                            busy_q      <= 1'b1;
                            step_q      <= 1'b1;
`ifdef SCAN_SEQUENCER_ONEHOT_EN
                            sel_oh_q    <= 8'(1) << first_ch;
`endif
                        end
                    end
                    DWELL: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else if (next_hit || (first_hit && cont_q)) begin
                            // Without a higher channel, first_ch is the wrap target.
                            sel_q  <= next_hit ? next_ch : first_ch;
                            cnt_q  <= bus.dwell_i;
                            step_q <= 1'b1;
`ifdef SCAN_SEQUENCER_ONEHOT_EN
                            sel_oh_q <= 8'(1) << (next_hit ? next_ch : first_ch);
`endif
                        end else begin
                            state_q     <= IDLE;
                            sel_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
`ifdef SCAN_SEQUENCER_ONEHOT_EN
                            sel_oh_q    <= '0;
`endif
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.sel_o       = sel_q;
    assign bus.sel_valid_o = sel_valid_q;
    assign bus.busy_o      = busy_q;
    assign bus.step_o      = step_q;
    assign bus.done_o      = done_q;
`ifdef SCAN_SEQUENCER_ONEHOT_EN
    assign bus.sel_oh_o    = sel_oh_q;
`endif
endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: sweep table, directed corner cases, random run vs. model.
// Honours SCAN_SEQUENCER_ONEHOT_EN for the sel_oh_o checks.
module tb_scan_sequencer;
    localparam int unsigned DWELL_W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    scan_sequencer_if #(.DWELL_W(DWELL_W)) bus ();

    scan_sequencer #(.DWELL_W(DWELL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: channel list rebuilt from the mask, elapsed cycles vs. hold length.
    bit m_busy, m_cont, m_step, m_done;
    int m_sel, m_age, m_hold;

    task automatic m_load(input int c);
        m_sel  = c;
        m_age  = 0;
        m_hold = int'(bus.dwell_i) + 1;
        m_busy = 1'b1;
        m_step = 1'b1;
    endtask

    task automatic model_step();
        int ch[$];
        int nxt;
        m_step = 1'b0;
        m_done = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0; m_cont = 1'b0; m_sel = 0; m_age = 0; m_hold = 0;
        end else if (bus.stop_i) begin
            m_busy = 1'b0;
        end else begin
            for (int k = 0; k < 8; k++) if (bus.mask_i[k]) ch.push_back(k);
            if (!m_busy) begin
                if (bus.start_i && ch.size() > 0) begin
                    m_load(ch[0]);
                    m_cont = bus.cont_i;
                end
            end else begin
                m_age++;
                if (m_age >= m_hold) begin
                    nxt = -1;
                    foreach (ch[k]) if (ch[k] > m_sel && nxt < 0) nxt = ch[k];
                    if (ch.size() == 0) begin
                        m_busy = 1'b0; m_done = 1'b1;
                    end else if (nxt >= 0) begin
                        m_load(nxt);
                    end else if (m_cont) begin
                        m_load(ch[0]);
                    end else begin
                        m_busy = 1'b0; m_done = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("sel", 32'(bus.sel_o), 32'(m_sel));
        check("sel_valid", 32'(bus.sel_valid_o), 32'(m_busy));
        check("busy", 32'(bus.busy_o), 32'(m_busy));
        check("step", 32'(bus.step_o), 32'(m_step));
        check("done", 32'(bus.done_o), 32'(m_done));
`ifdef SCAN_SEQUENCER_ONEHOT_EN
        check("sel_oh", 32'(bus.sel_oh_o), m_busy ? (32'd1 << m_sel) : 32'd0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic go_idle();
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        for (int i = 0; i < 100 && bus.busy_o; i++) tick();
        check("idle_reached", 32'(bus.busy_o), 32'd0);
    endtask

    typedef struct {
        logic [7:0] mask;
        logic [7:0] dwell;
        int         first;
        int         valid_cycles;
        int         steps;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int vcnt, scnt, seen_done;
        int exp_seq[6];

        vecs[0] = '{8'hFF, 8'd0, 0, 8, 8};
        vecs[1] = '{8'hA4, 8'd2, 2, 9, 3};
        vecs[2] = '{8'h01, 8'd3, 0, 4, 1};
        vecs[3] = '{8'h80, 8'd0, 7, 1, 1};
        vecs[4] = '{8'h81, 8'd1, 0, 4, 2};
        vecs[5] = '{8'h18, 8'd4, 3, 10, 2};

        rst_n = 1'b0;
        bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.cont_i = 1'b0;
        bus.mask_i = 8'h00; bus.dwell_i = '0;
        tick(); tick();
        check("reset_sel", 32'(bus.sel_o), 32'd0);
        check("reset_busy", 32'(bus.busy_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single-sweep table
        foreach (vecs[v]) begin
            go_idle();
            bus.mask_i = vecs[v].mask; bus.dwell_i = vecs[v].dwell; bus.cont_i = 1'b0;
            bus.start_i = 1'b1;
            tick();
            bus.start_i = 1'b0;
            check("tbl_first_sel", 32'(bus.sel_o), 32'(vecs[v].first));
            vcnt = 0; scnt = 0; seen_done = 0;
            for (int c = 0; c < 300; c++) begin
                if (bus.done_o) begin seen_done = 1; break; end
                if (bus.sel_valid_o) vcnt++;
                if (bus.step_o) scnt++;
                tick();
            end
            check("tbl_done_seen", 32'(seen_done), 32'd1);
            check("tbl_valid_cycles", 32'(vcnt), 32'(vecs[v].valid_cycles));
            check("tbl_steps", 32'(scnt), 32'(vecs[v].steps));
            tick();
            check("tbl_busy_after", 32'(bus.busy_o), 32'd0);
        end

        // Continuous 0,0,7,7,0,0 then stop
        go_idle();
        exp_seq = '{0, 0, 7, 7, 0, 0};
        bus.mask_i = 8'h81; bus.dwell_i = 8'd1; bus.cont_i = 1'b1; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check("cont_seq", 32'(bus.sel_o), 32'(exp_seq[k]));
            check("cont_valid", 32'(bus.sel_valid_o), 32'd1);
            tick();
        end
        bus.stop_i = 1'b1;
        tick();
        bus.stop_i = 1'b0;
        check("stop_valid", 32'(bus.sel_valid_o), 32'd0);
        check("stop_done", 32'(bus.done_o), 32'd0);

        // Mask emptied mid continuous scan
        bus.mask_i = 8'hFF; bus.dwell_i = 8'd3; bus.cont_i = 1'b1; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick();
        bus.mask_i = 8'h00;
        seen_done = 0;
        for (int c = 0; c < 10 && !seen_done; c++) begin
            tick();
            if (bus.done_o) seen_done = 1;
        end
        check("empty_done", 32'(seen_done), 32'd1);
        check("empty_valid", 32'(bus.sel_valid_o), 32'd0);

        // start and stop together in IDLE
        bus.mask_i = 8'hFF; bus.start_i = 1'b1; bus.stop_i = 1'b1;
        tick();
        bus.start_i = 1'b0; bus.stop_i = 1'b0;
        check("startstop_busy", 32'(bus.busy_o), 32'd0);
        check("startstop_step", 32'(bus.step_o), 32'd0);

        // Restart in the done cycle
        bus.mask_i = 8'h01; bus.dwell_i = 8'd0; bus.cont_i = 1'b0; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick();
        check("restart_done", 32'(bus.done_o), 32'd1);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        check("restart_valid", 32'(bus.sel_valid_o), 32'd1);
        check("restart_step", 32'(bus.step_o), 32'd1);
        go_idle();

        // Reset while dwelling on channel 4
        bus.mask_i = 8'h30; bus.dwell_i = 8'd5; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        check("rst4_sel", 32'(bus.sel_o), 32'd4);
`ifdef SCAN_SEQUENCER_ONEHOT_EN
        check("rst4_oh", 32'(bus.sel_oh_o), 32'h10);
`endif
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst4_after_sel", 32'(bus.sel_o), 32'd0);
        check("rst4_after_valid", 32'(bus.sel_valid_o), 32'd0);
`ifdef SCAN_SEQUENCER_ONEHOT_EN
        check("rst4_after_oh", 32'(bus.sel_oh_o), 32'h00);
`endif

        // Random run against the model
        for (int c = 0; c < 4000; c++) begin
            bus.start_i = ($urandom % 4) == 0;
            bus.stop_i  = ($urandom % 50) == 0;
            if (($urandom % 8) == 0) bus.cont_i = 1'($urandom);
            if (($urandom % 12) == 0) bus.mask_i = (($urandom % 5) == 0) ? 8'h00 : 8'($urandom);
            bus.dwell_i = 8'($urandom_range(0, 3));
            rst_n = ($urandom % 300) != 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
